ext_mem_arbiter: RTL
====================

# ext_mem_arbiter

Shares the single external memory port among the six accelerator load/store units: inference configuration, input feature map, output feature map, expansion kernels, pointwise kernels and depthwise kernels. Each unit issues bursts with a region-local word offset. The block relocates the offset by the unit's region base, arbitrates round-robin, and locks the grant for one full burst. It routes read beats back to the owner and muxes the owner's write beats out. It sits between the layer sequencer's load units and the memory controller.

## Interface
- ADDR_W, 27, memory word-address width.
- DATA_W, 32, data beat width.
- LEN_W, 8, burst length field width in beats.
- BASE_0..BASE_5, 0 / 2·2^20 / 24·2^20 / 46·2^20 / 66·2^20 / 84·2^20, region bases: inf_conv, fmi, fmo, kex, kpw, kdw.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  6  burst request per requester.
- req_ready  out  6  one-cycle acceptance pulse.
- req_off  in  6·ADDR_W  region-local start offset.
- req_len  in  6·LEN_W  burst length in beats.
- req_we  in  6  1 = write burst.
- rd_data  out  DATA_W  read beat, broadcast to all requesters.
- rd_valid  out  6  one-hot read beat strobe to the owner.
- wr_data  in  6·DATA_W  write beat from each requester.
- wr_valid  in  6  write beat valid.
- wr_ready  out  6  write beat accepted.
- mem_cmd_valid / mem_cmd_ready  out / in  1 / 1  command handshake.
- mem_addr  out  ADDR_W  absolute word address.
- mem_len  out  LEN_W  burst length.
- mem_we  out  1  write command.
- mem_wdata / mem_wvalid / mem_wready  out / out / in  DATA_W / 1 / 1  write beat channel.
- mem_rdata / mem_rvalid  in / in  DATA_W / 1  read beat channel; there is no backpressure.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  current owner; 7 when idle.
- err_oob  out  1  one-cycle out-of-bounds pulse (only with the macro, see Configuration).

## Operation
- FSM states:
  - IDLE -> CMD on a grant.
  - CMD -> DATA on mem_cmd_valid & mem_cmd_ready.
  - DATA -> IDLE when the last beat completes.
- Arbitration, in IDLE only:
  - Scan req_valid starting at rr_ptr, ascending, modulo 6; the first asserted requester g wins.
  - req_ready[g] = 1 for that cycle.
  - Latch owner = g, mem_addr = (BASE_g + off_g) mod 2^ADDR_W, mem_len = len_g, mem_we = we_g.
- Zero-length request (len_g = 0):
  - Accepted (req_ready pulses) but no command is issued.
  - FSM stays in IDLE; rr_ptr = g+1.
- CMD:
  - mem_cmd_valid = 1 and the command fields are held stable until mem_cmd_ready.
  - Set beat counter = len.
- DATA, read burst:
  - rd_valid[owner] = mem_rvalid; rd_data = mem_rdata, combinational pass-through.
  - Each mem_rvalid decrements the counter.
- DATA, write burst:
  - mem_wvalid = wr_valid[owner]; mem_wdata = wr_data[owner]; wr_ready[owner] = mem_wready.
  - Each mem_wvalid & mem_wready handshake decrements the counter.
- Last beat (counter = 1 and a beat occurs): go to IDLE; rr_ptr = owner+1 mod 6.
- Stray or off-owner traffic:
  - mem_rvalid outside DATA, or during a write burst, is dropped; rd_valid stays 0.
  - wr_ready stays 0 for every non-owner requester.
- Requesters must hold req_off, req_len and req_we stable while req_valid is high.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, counter 0, grant_id 7.
  - req_ready, rd_valid, wr_ready, mem_cmd_valid, mem_wvalid, mem_we, busy, err_oob all 0.
  - mem_addr 0, mem_len 0.
- Reset mid-burst: same values on the next edge; in-flight beats are abandoned.
- Latency:
  - Request accepted at cycle T; mem_cmd_valid rises at T+1.
  - After the last beat at cycle L, the next grant is possible at L+1.
- Burst lock: no re-arbitration until the last beat, even if a higher-ranked requester asserts.
- Simultaneous requests: rr_ptr order decides; each requester is served at most once every 6 grants under full load.

## Configuration
- EXT_ARB_BOUND_CHECK_EN defined:
  - At grant, compare off_g + len_g against the region size.
  - Region size = BASE_{g+1} - BASE_g; region 5 uses 2^ADDR_W - BASE_5.
  - If the sum exceeds the size: req_ready[g] and err_oob pulse together, no command is issued, FSM stays in IDLE, rr_ptr = g+1.
- Macro undefined:
  - No check; err_oob is tied to 0.
  - The address wraps modulo 2^ADDR_W.

## Test plan
- fmi read, off = 0x10, len = 4, mem_cmd_ready at 1st cycle, 4 rvalid beats:
  - mem_addr = 0x200010.
  - rd_valid[1] pulses 4 times.
  - IDLE, with busy low, on the cycle after the 4th beat.
- kex, kpw and kdw request together with rr_ptr = 0, len 2 each: grants in order 3, 4, 5; grant_id never changes mid-burst.
- fmo write, off = 0, len = 3, mem_wready toggling 1,0,1,0,1:
  - mem_addr = 0x1800000.
  - Exactly 3 handshakes; wr_ready[2] mirrors mem_wready.
- len = 0 from inf_conv: req_ready[0] pulses; mem_cmd_valid stays 0; rr_ptr = 1.
- rst asserted mid-read burst, after beat 2 of 8: all outputs at reset values; the next fmi request is granted normally.
- With EXT_ARB_BOUND_CHECK_EN, kdw off = 2^ADDR_W - BASE_5 - 1, len 4: err_oob pulses; no command is issued.

Source files
------------

// File: rtl/ext_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around ext_mem_arbiter.
// slave = arbiter view; master = requesters plus memory controller view.
interface ext_mem_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    localparam int N = 6;

    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*ADDR_W-1:0] req_off;
    logic [N*LEN_W-1:0]  req_len;
    logic [N-1:0]        req_we;
    logic [DATA_W-1:0]   rd_data;
    logic [N-1:0]        rd_valid;
    logic [N*DATA_W-1:0] wr_data;
    logic [N-1:0]        wr_valid;
    logic [N-1:0]        wr_ready;
    logic                mem_cmd_valid;
    logic                mem_cmd_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [LEN_W-1:0]    mem_len;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_wvalid;
    logic                mem_wready;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rvalid;
    logic                busy;
    logic [2:0]          grant_id;
    logic                err_oob;

    modport slave (
        input  req_valid, req_off, req_len, req_we,
        input  wr_data, wr_valid,
        input  mem_cmd_ready, mem_wready,
        input  mem_rdata, mem_rvalid,
        output req_ready, rd_data, rd_valid, wr_ready,
        output mem_cmd_valid, mem_addr, mem_len, mem_we,
        output mem_wdata, mem_wvalid,
        output busy, grant_id, err_oob
    );

    modport master (
        output req_valid, req_off, req_len, req_we,
        output wr_data, wr_valid,
        output mem_cmd_ready, mem_wready,
        output mem_rdata, mem_rvalid,
        input  req_ready, rd_data, rd_valid, wr_ready,
        input  mem_cmd_valid, mem_addr, mem_len, mem_we,
        input  mem_wdata, mem_wvalid,
        input  busy, grant_id, err_oob
    );
endinterface

// File: rtl/ext_mem_arbiter.sv
// Round-robin, burst-locked sharing of one external memory port by six units.
// Define EXT_ARB_BOUND_CHECK_EN to reject bursts that overrun their region.
module ext_mem_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter logic [ADDR_W-1:0] BASE_0 = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] BASE_1 = ADDR_W'(2 * 2**20),
    parameter logic [ADDR_W-1:0] BASE_2 = ADDR_W'(24 * 2**20),
    parameter logic [ADDR_W-1:0] BASE_3 = ADDR_W'(46 * 2**20),
    parameter logic [ADDR_W-1:0] BASE_4 = ADDR_W'(66 * 2**20),
    parameter logic [ADDR_W-1:0] BASE_5 = ADDR_W'(84 * 2**20)
) (
    input  logic            clk,
    input  logic            rst,
    ext_mem_arbiter_if.slave bus
);
    localparam int N = 6;
    localparam logic [N-1:0] ONE = N'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    function automatic logic [ADDR_W-1:0] base_of(
        input logic [2:0] g
    );
        case (g)
            3'd0:    base_of = BASE_0;
            3'd1:    base_of = BASE_1;
            3'd2:    base_of = BASE_2;
            3'd3:    base_of = BASE_3;
            3'd4:    base_of = BASE_4;
            default: base_of = BASE_5;
        endcase
    endfunction

    function automatic logic [2:0] next_id(
        input logic [2:0] g
    );
        return (g == 3'd5) ? 3'd0 : g + 3'd1;
    endfunction

    logic [1:0]        state;
    logic [2:0]        rr_ptr;
    logic [2:0]        owner;
    logic [LEN_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              we_q;

    logic       found;
    logic [2:0] gnt;
    logic [2:0] cand;
    logic [3:0] sum;

    // Rotating priority scan starting at rr_ptr
    always_comb begin
        found = 1'b0;
        gnt   = 3'd0;
        cand  = 3'd0;
        sum   = 4'd0;
        for (int i = 0; i < N; i++) begin
            sum  = {1'b0, rr_ptr} + 4'(i);
            cand = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    logic [ADDR_W-1:0] g_off;
    logic [LEN_W-1:0]  g_len;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;

    assign g_off  = bus.req_off[gnt*ADDR_W +: ADDR_W];
    assign g_len  = bus.req_len[gnt*LEN_W +: LEN_W];
    assign g_we   = bus.req_we[gnt];
    assign g_addr = base_of(gnt) + g_off;

    logic oob;
`ifdef EXT_ARB_BOUND_CHECK_EN
    logic [ADDR_W:0] span;
    logic [ADDR_W:0] top;
    logic [ADDR_W:0] limit;

    // Last region extends to the top of the address space
    always_comb begin
        span  = {1'b0, g_off} + (ADDR_W+1)'(g_len);
        top   = (gnt == 3'd5) ? {1'b1, {ADDR_W{1'b0}}}
                              : {1'b0, base_of(next_id(gnt))};
        limit = top - {1'b0, base_of(gnt)};
        oob   = span > limit;
    end
`else
    assign oob = 1'b0;
`endif

    logic accept;
    logic issue;

    assign accept = (state == S_IDLE) && found && !rst;
    assign issue  = accept && (g_len != '0) && !oob;

    logic in_data;
    logic rd_beat;
    logic wr_beat;
    logic beat;

    assign in_data = (state == S_DATA);
    assign rd_beat = in_data && !we_q && bus.mem_rvalid;
    assign wr_beat = in_data && we_q && bus.wr_valid[owner]
                     && bus.mem_wready;
    assign beat    = rd_beat || wr_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= 3'd0;
            owner  <= 3'd0;
            cnt    <= '0;
            addr_q <= '0;
            len_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (issue) begin
                        state  <= S_CMD;
                        owner  <= gnt;
                        addr_q <= g_addr;
                        len_q  <= g_len;
                        we_q   <= g_we;
                    end else if (accept) begin
                        rr_ptr <= next_id(gnt);
                    end
                end
                S_CMD: begin
                    if (bus.mem_cmd_ready) begin
                        state <= S_DATA;
                        cnt   <= len_q;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            state  <= S_IDLE;
                            rr_ptr <= next_id(owner);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = accept ? (ONE << gnt) : '0;
    assign bus.err_oob   = accept && oob;

    assign bus.mem_cmd_valid = (state == S_CMD);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_len       = len_q;
    assign bus.mem_we        = we_q;

    assign bus.rd_data  = bus.mem_rdata;
    assign bus.rd_valid = rd_beat ? (ONE << owner) : '0;

    assign bus.mem_wvalid = in_data && we_q && bus.wr_valid[owner];
    assign bus.mem_wdata  = bus.wr_data[owner*DATA_W +: DATA_W];
    assign bus.wr_ready   = (in_data && we_q && bus.mem_wready)
                            ? (ONE << owner) : '0;

    assign bus.busy     = (state != S_IDLE);
    assign bus.grant_id = bus.busy ? owner : 3'd7;
endmodule
